// File: rtl/bubble_page_loader.sv
// Serialises a bootloader or user page byte stream into the bubble out-buffer, one bit per 3-cycle write.
// Optional build macro LOADER_CHECKSUM_EN enables the running byte checksum on CHECKSUM.
module bubble_page_loader #(
  parameter int unsigned BOOT_BASE  = 4106,
  parameter int unsigned BOOT_BYTES = 480,
  parameter int unsigned USER_BASE  = 14342,
  parameter int unsigned USER_BYTES = 128
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        LOAD_START,
  input  logic        LOAD_MODE,
  input  logic        BYTE_VALID,
  input  logic [7:0]  BYTE_DATA,
  output logic        BYTE_READY,
  output logic [14:0] OUTBUFWADDR,
  output logic        OUTBUFWCLK,
  output logic        OUTBUFWDATA,
  output logic        LOAD_BUSY,
  output logic        LOAD_DONE,
  output logic [7:0]  CHECKSUM
);

  localparam int unsigned AW = 15;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_ptr;
  logic [AW-1:0]   r_addr;
  logic [CW-1:0]   r_len;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit;
  logic            r_ready;
  logic            r_wclk;
  logic            r_wdata;
  logic            r_busy;
  logic            r_done;
  logic            w_accept;

  assign w_accept = (r_state == S_FETCH) && BYTE_VALID && r_ready;

  // Loader FSM; address/data registers are loaded on the edge that enters SETUP
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_ready <= 1'b0;
      r_wclk  <= 1'b0;
      r_wdata <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (LOAD_START) begin
            r_ptr   <= LOAD_MODE ? AW'(USER_BASE) : AW'(BOOT_BASE);
            r_len   <= LOAD_MODE ? CW'(USER_BYTES) : CW'(BOOT_BYTES);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_accept) begin
            r_cnt   <= r_cnt + CW'(1);
            r_ready <= 1'b0;
            r_bit   <= '0;
            r_addr  <= r_ptr;
            r_wdata <= BYTE_DATA[0];
            r_shift <= {1'b0, BYTE_DATA[7:1]};
            r_ptr   <= r_ptr + AW'(1);
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_wclk  <= 1'b1;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          r_wclk  <= 1'b0;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (r_bit != 3'd7) begin
            r_bit   <= r_bit + 3'd1;
            r_addr  <= r_ptr;
            r_wdata <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_ptr   <= r_ptr + AW'(1);
            r_state <= S_SETUP;
          end else if (r_cnt == r_len) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;

  // Modulo-256 sum of accepted bytes, held until the next load request
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_sum <= '0;
    end else if ((r_state == S_IDLE) && LOAD_START) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + BYTE_DATA;
    end
  end

  assign CHECKSUM = r_sum;
`else
  assign CHECKSUM = 8'd0;
`endif

  assign BYTE_READY  = r_ready;
  assign OUTBUFWADDR = r_addr;
  assign OUTBUFWCLK  = r_wclk;
  assign OUTBUFWDATA = r_wdata;
  assign LOAD_BUSY   = r_busy;
  assign LOAD_DONE   = r_done;

endmodule

// File: tb/tb_bubble_page_loader.sv
// Scoreboard bench for bubble_page_loader: expected out-buffer writes and completions are queued
// at stimulus time and consumed by a monitor that watches strobes and LOAD_DONE.
module tb_bubble_page_loader;

  localparam int unsigned BOOT_BASE  = 4106;
  localparam int unsigned BOOT_BYTES = 480;
  localparam int unsigned USER_BASE  = 14342;
  localparam int unsigned USER_BYTES = 128;

  logic        MCLK;
  logic        nRESET;
  logic        LOAD_START;
  logic        LOAD_MODE;
  logic        BYTE_VALID;
  logic [7:0]  BYTE_DATA;
  logic        BYTE_READY;
  logic [14:0] OUTBUFWADDR;
  logic        OUTBUFWCLK;
  logic        OUTBUFWDATA;
  logic        LOAD_BUSY;
  logic        LOAD_DONE;
  logic [7:0]  CHECKSUM;

  bubble_page_loader #(
    .BOOT_BASE (BOOT_BASE),
    .BOOT_BYTES(BOOT_BYTES),
    .USER_BASE (USER_BASE),
    .USER_BYTES(USER_BYTES)
  ) dut (
    .MCLK       (MCLK),
    .nRESET     (nRESET),
    .LOAD_START (LOAD_START),
    .LOAD_MODE  (LOAD_MODE),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_DATA  (BYTE_DATA),
    .BYTE_READY (BYTE_READY),
    .OUTBUFWADDR(OUTBUFWADDR),
    .OUTBUFWCLK (OUTBUFWCLK),
    .OUTBUFWDATA(OUTBUFWDATA),
    .LOAD_BUSY  (LOAD_BUSY),
    .LOAD_DONE  (LOAD_DONE),
    .CHECKSUM   (CHECKSUM)
  );

  typedef struct packed {
    logic [14:0] addr;
    logic        val;
  } strobe_t;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  sum;
  } done_t;

  strobe_t     exp_q[$];
  done_t       done_q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  logic        prev_wclk = 1'b0;

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  always @(posedge MCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: consumes expected writes on each rising strobe and expected completions on LOAD_DONE
  always @(negedge MCLK) begin
    strobe_t s;
    done_t   d;
    if (nRESET) begin
      if (OUTBUFWCLK && !prev_wclk) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got addr %0d want none", OUTBUFWADDR);
        end else begin
          s = exp_q.pop_front();
          check("strobe_addr", 32'(OUTBUFWADDR), 32'(s.addr));
          check("strobe_data", 32'(OUTBUFWDATA), 32'(s.val));
        end
      end
      if (BYTE_READY) begin
        check("busy_while_ready", 32'(LOAD_BUSY), 32'd1);
        check("no_strobe_while_ready", 32'(OUTBUFWCLK), 32'd0);
      end
      if (LOAD_DONE) begin
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got pulse at cycle %0d want none", cyc);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(d.cyc));
          check("busy_at_done", 32'(LOAD_BUSY), 32'd0);
          check("checksum_at_done", 32'(CHECKSUM), 32'(d.sum));
          check("strobes_left_at_done", 32'(exp_q.size()), 32'd0);
        end
      end
    end
    prev_wclk = OUTBUFWCLK;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(OUTBUFWADDR), 32'd0);
    check({tag, "_wclk"},  32'(OUTBUFWCLK),  32'd0);
    check({tag, "_wdata"}, 32'(OUTBUFWDATA), 32'd0);
    check({tag, "_ready"}, 32'(BYTE_READY),  32'd0);
    check({tag, "_busy"},  32'(LOAD_BUSY),   32'd0);
    check({tag, "_done"},  32'(LOAD_DONE),   32'd0);
    check({tag, "_sum"},   32'(CHECKSUM),    32'd0);
  endtask

  // One load: queue the expected writes/completion, then act as the byte source
  task automatic run_load(input logic mode, input logic [7:0] data[$], input int gaps[$],
                          input int spurious_at, input int abort_at);
    int unsigned base;
    int unsigned n;
    int unsigned gap_sum;
    int unsigned start_cyc;
    logic [7:0]  sum;
    strobe_t     s;
    done_t       d;
    int          w;
    base    = mode ? USER_BASE : BOOT_BASE;
    n       = data.size();
    gap_sum = 0;
    sum     = 8'd0;
    @(negedge MCLK);
    LOAD_MODE  = mode;
    LOAD_START = 1'b1;
    @(negedge MCLK);
    LOAD_START = 1'b0;
    start_cyc  = cyc;
    check("busy_after_start", 32'(LOAD_BUSY), 32'd1);
    for (int i = 0; i < int'(n); i++) begin
      for (int b = 0; b < 8; b++) begin
        s.addr = 15'((base + 8 * i + b) % 32768);
        s.val  = data[i][b];
        exp_q.push_back(s);
      end
      gap_sum += gaps[i];
      sum     += data[i];
    end
    if (abort_at < 0) begin
      d.cyc = start_cyc + 25 * n + gap_sum;
`ifdef LOADER_CHECKSUM_EN
      d.sum = sum;
`else
      d.sum = 8'd0;
`endif
      done_q.push_back(d);
    end
    for (int i = 0; i < int'(n); i++) begin
      w = 0;
      while (!BYTE_READY && w < 200) begin
        @(negedge MCLK);
        w++;
      end
      if (!BYTE_READY) begin
        total++;
        bad++;
        $display("FAIL ready_timeout: got no BYTE_READY for byte %0d want ready", i);
        exp_q.delete();
        done_q.delete();
        return;
      end
      repeat (gaps[i]) @(negedge MCLK);
      if (i == spurious_at) begin
        LOAD_START = 1'b1;
        LOAD_MODE  = ~mode;
      end
      BYTE_VALID = 1'b1;
      BYTE_DATA  = data[i];
      @(negedge MCLK);
      BYTE_VALID = 1'b0;
      LOAD_START = 1'b0;
      BYTE_DATA  = 8'($urandom);
      if (i == abort_at) begin
        repeat (4) @(posedge MCLK);
        #2 nRESET = 1'b0;
        #1 check_all_zero("mid_reset");
        exp_q.delete();
        repeat (3) @(negedge MCLK);
        check_all_zero("held_reset");
        #2 nRESET = 1'b1;
        repeat (40) @(negedge MCLK);
        check("no_activity_after_abort", 32'(LOAD_BUSY), 32'd0);
        return;
      end
    end
    w = 0;
    while (done_q.size() != 0 && w < 400) begin
      @(negedge MCLK);
      w++;
    end
    if (done_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no LOAD_DONE want pulse at cycle %0d", done_q[0].cyc);
      done_q.delete();
      exp_q.delete();
    end
    @(negedge MCLK);
    check("done_one_cycle", 32'(LOAD_DONE), 32'd0);
    check("idle_not_busy", 32'(LOAD_BUSY), 32'd0);
  endtask

  task automatic make_load(input logic mode, input int pat, output logic [7:0] data[$], output int gaps[$]);
    int unsigned n;
    n = mode ? USER_BYTES : BOOT_BYTES;
    data.delete();
    gaps.delete();
    for (int i = 0; i < int'(n); i++) begin
      case (pat)
        0:       data.push_back(8'(i % 224));
        1:       data.push_back(8'h03);
        default: data.push_back(8'($urandom));
      endcase
      if (pat >= 2 && $urandom_range(0, 3) == 0) gaps.push_back(int'($urandom_range(1, 4)));
      else gaps.push_back(0);
    end
  endtask

  initial begin
    logic [7:0] data[$];
    int         gaps[$];
    nRESET     = 1'b0;
    LOAD_START = 1'b0;
    LOAD_MODE  = 1'b0;
    BYTE_VALID = 1'b0;
    BYTE_DATA  = 8'd0;
    repeat (3) @(negedge MCLK);
    check_all_zero("reset");
    #2 nRESET = 1'b1;
    repeat (2) @(negedge MCLK);

    // Boot load, deterministic ramp, source always valid
    make_load(1'b0, 0, data, gaps);
    run_load(1'b0, data, gaps, -1, -1);

    // User load: 0xA5 first, 10-cycle stall before byte 3, ignored restart request mid-load
    make_load(1'b1, 2, data, gaps);
    data[0] = 8'hA5;
    gaps[3] = 10;
    run_load(1'b1, data, gaps, 60, -1);

    // Boot load abandoned by reset after byte 50
    make_load(1'b0, 2, data, gaps);
    run_load(1'b0, data, gaps, -1, 50);

    // Fresh boot load after the abort must restart at the boot base
    make_load(1'b0, 2, data, gaps);
    run_load(1'b0, data, gaps, -1, -1);

    // User load of constant 0x03 for the checksum
    make_load(1'b1, 1, data, gaps);
    run_load(1'b1, data, gaps, -1, -1);
    repeat (3) @(negedge MCLK);
`ifdef LOADER_CHECKSUM_EN
    check("checksum_hold", 32'(CHECKSUM), 32'h80);
`else
    check("checksum_hold", 32'(CHECKSUM), 32'h00);
`endif

    check("leftover_strobes", 32'(exp_q.size()), 32'd0);
    check("leftover_done", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
